// File: rtl/ddr3_traffic_master.sv
// DDR3 traffic master: writes NUM_CMDS commands of a known pattern, reads them back and counts mismatches.
// Define DDR3_TM_LFSR_PATTERN_EN to use a 64-bit Galois LFSR data pattern instead of the address pattern.
module ddr3_traffic_master #(
  parameter logic [26:0] ADDR_BASE = 27'h0,
  parameter int          NUM_CMDS  = 1024,
  parameter logic [4:0]  BURST_CNT = 5'd4
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        start,
  output logic        init_start,
  input  logic        init_done,
  output logic [3:0]  cmd,
  output logic [26:0] addr,
  output logic [4:0]  cmd_burst_cnt,
  output logic        ofly_burst_len,
  output logic        cmd_valid,
  input  logic        cmd_rdy,
  input  logic        datain_rdy,
  output logic [63:0] write_data,
  output logic [7:0]  data_mask,
  input  logic [63:0] read_data,
  input  logic        read_data_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [2:0]  dbg_state
);

  // Handshake: a command moves only on a cycle where cmd_valid and cmd_rdy are both 1; while
  // cmd_valid=1 and cmd_rdy=0 the cmd/addr/cmd_burst_cnt outputs hold. A write beat is consumed on
  // every datain_rdy=1 cycle in WR_DATA; a read beat is taken on every read_data_valid=1 cycle.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] WR_CMD  = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] RD_CMD  = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;
  localparam logic [2:0] FINISH  = 3'd6;

  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0001;

  localparam int          BURSTS      = (BURST_CNT == 5'd0) ? 32 : int'(BURST_CNT);
  localparam logic [5:0]  LAST_BEAT   = 6'(2 * BURSTS - 1);
  localparam logic [15:0] LAST_CMD    = 16'(NUM_CMDS - 1);
  localparam logic [26:0] ADDR_STEP   = 27'(8 * BURSTS);
  localparam logic [23:0] TOTAL_BEATS = 24'(2 * BURSTS * NUM_CMDS);

  logic [2:0]  state;
  logic [15:0] cmd_cnt;
  logic [5:0]  wbeat;
  logic [23:0] rd_k;
  logic        start_fire;
  logic        wr_fire;
  logic        wr_last;
  logic        rd_fire;
  logic [63:0] wr_pattern;
  logic [63:0] exp_data;

  assign start_fire = (state == IDLE) && start;
  assign wr_fire    = (state == WR_DATA) && datain_rdy;
  assign wr_last    = wr_fire && (wbeat == LAST_BEAT) && (cmd_cnt == LAST_CMD);
  assign rd_fire    = ((state == RD_CMD) || (state == RD_WAIT)) && read_data_valid &&
                      (rd_k != TOTAL_BEATS);

  assign busy           = (state != IDLE);
  assign init_start     = (state == INIT);
  assign cmd_valid      = (state == WR_CMD) || (state == RD_CMD);
  assign cmd            = (state == WR_CMD) ? CMD_WRITE : (state == RD_CMD) ? CMD_READ : 4'b0000;
  assign cmd_burst_cnt  = cmd_valid ? BURST_CNT : 5'd0;
  assign ofly_burst_len = 1'b0;
  assign data_mask      = 8'h00;
  assign write_data     = (state == WR_DATA) ? wr_pattern : 64'h0;
  assign dbg_state      = state;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= 27'h0;
      cmd_cnt   <= 16'd0;
      wbeat     <= 6'd0;
      rd_k      <= 24'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 16'h0;
            addr      <= ADDR_BASE;
            cmd_cnt   <= 16'd0;
            wbeat     <= 6'd0;
            rd_k      <= 24'd0;
            state     <= init_done ? WR_CMD : INIT;
          end
        end
        INIT: begin
          if (init_done) state <= WR_CMD;
        end
        WR_CMD: begin
          if (cmd_rdy) begin
            wbeat <= 6'd0;
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (datain_rdy) begin
            wbeat <= wbeat + 6'd1;
            if (wbeat == LAST_BEAT) begin
              wbeat <= 6'd0;
              if (cmd_cnt == LAST_CMD) begin
                // Read phase replays the same address range from the top.
                cmd_cnt <= 16'd0;
                addr    <= ADDR_BASE;
                state   <= RD_CMD;
              end else begin
                cmd_cnt <= cmd_cnt + 16'd1;
                addr    <= addr + ADDR_STEP;
                state   <= WR_CMD;
              end
            end
          end
        end
        RD_CMD: begin
          if (cmd_rdy) begin
            if (cmd_cnt == LAST_CMD) begin
              state <= RD_WAIT;
            end else begin
              cmd_cnt <= cmd_cnt + 16'd1;
              addr    <= addr + ADDR_STEP;
            end
          end
        end
        RD_WAIT: begin
          if (rd_k == TOTAL_BEATS) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          pass  <= (err_count == 16'h0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Read returns overlap the read command stream, so checking runs in RD_CMD and RD_WAIT.
      if (rd_fire) begin
        rd_k <= rd_k + 24'd1;
        if ((read_data != exp_data) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
    end
  end

`ifdef DDR3_TM_LFSR_PATTERN_EN
  logic [63:0] wr_lfsr;
  logic [63:0] rd_lfsr;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_lfsr <= 64'h1;
      rd_lfsr <= 64'h1;
    end else begin
      if (start_fire) wr_lfsr <= 64'h1;
      else if (wr_fire) wr_lfsr <= lfsr_step(wr_lfsr);
      if (wr_last) rd_lfsr <= 64'h1;
      else if (rd_fire) rd_lfsr <= lfsr_step(rd_lfsr);
    end
  end

  assign wr_pattern = wr_lfsr;
  assign exp_data   = rd_lfsr;
`else
  logic [9:0]  wr_k;
  logic [26:0] rd_addr;
  logic [26:0] wr_beat_addr;

  // Each beat covers 4 address units, so beat addresses step by 4 across the whole pass.
  assign wr_beat_addr = addr + {19'd0, wbeat, 2'b00};
  assign wr_pattern   = {wr_beat_addr, ~wr_beat_addr, wr_k};
  assign exp_data     = {rd_addr, ~rd_addr, rd_k[9:0]};

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_k    <= 10'd0;
      rd_addr <= 27'h0;
    end else begin
      if (start_fire) begin
        wr_k    <= 10'd0;
        rd_addr <= ADDR_BASE;
      end
      if (wr_fire) wr_k <= wr_k + 10'd1;
      if (rd_fire) rd_addr <= rd_addr + 27'd4;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_traffic_master.sv
// Bench for ddr3_traffic_master: randomized controller/memory models, reference pattern computed from beat number.
module tb_ddr3_traffic_master;
  localparam logic [3:0]  WR     = 4'b0010;
  localparam logic [3:0]  RD     = 4'b0001;
  localparam int          BC_A   = 4;
  localparam int          N_A    = 2;
  localparam int          BC_B   = 1;
  localparam int          N_B    = 2;
  localparam logic [26:0] BASE_A = 27'h0;
  localparam logic [26:0] BASE_B = 27'h7FFFFF8;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic sclk  = 1'b0;
  logic rst_n = 1'b1;
  initial forever #5 sclk = ~sclk;

  // ---------------- DUT A ----------------
  logic        start_a = 1'b0, init_done_a = 1'b0;
  logic        cmd_rdy_a = 1'b0, datain_rdy_a = 1'b0, read_data_valid_a = 1'b0;
  logic [63:0] read_data_a = 64'h0;
  logic        init_start_a, ofly_a, cmd_valid_a, busy_a, done_a, pass_a;
  logic [3:0]  cmd_a;
  logic [26:0] addr_a;
  logic [4:0]  cmd_burst_cnt_a;
  logic [63:0] write_data_a;
  logic [7:0]  data_mask_a;
  logic [15:0] err_count_a;
  logic [2:0]  dbg_state_a;

  ddr3_traffic_master #(.ADDR_BASE(BASE_A), .NUM_CMDS(N_A), .BURST_CNT(5'(BC_A))) dut_a (
    .sclk(sclk), .rst_n(rst_n), .start(start_a), .init_start(init_start_a), .init_done(init_done_a),
    .cmd(cmd_a), .addr(addr_a), .cmd_burst_cnt(cmd_burst_cnt_a), .ofly_burst_len(ofly_a),
    .cmd_valid(cmd_valid_a), .cmd_rdy(cmd_rdy_a), .datain_rdy(datain_rdy_a),
    .write_data(write_data_a), .data_mask(data_mask_a), .read_data(read_data_a),
    .read_data_valid(read_data_valid_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .dbg_state(dbg_state_a)
  );

  // ---------------- DUT B (address wrap) ----------------
  logic        start_b = 1'b0, init_done_b = 1'b1;
  logic        cmd_rdy_b = 1'b0, datain_rdy_b = 1'b0, read_data_valid_b = 1'b0;
  logic [63:0] read_data_b = 64'h0;
  logic        init_start_b, ofly_b, cmd_valid_b, busy_b, done_b, pass_b;
  logic [3:0]  cmd_b;
  logic [26:0] addr_b;
  logic [4:0]  cmd_burst_cnt_b;
  logic [63:0] write_data_b;
  logic [7:0]  data_mask_b;
  logic [15:0] err_count_b;
  logic [2:0]  dbg_state_b;

  ddr3_traffic_master #(.ADDR_BASE(BASE_B), .NUM_CMDS(N_B), .BURST_CNT(5'(BC_B))) dut_b (
    .sclk(sclk), .rst_n(rst_n), .start(start_b), .init_start(init_start_b), .init_done(init_done_b),
    .cmd(cmd_b), .addr(addr_b), .cmd_burst_cnt(cmd_burst_cnt_b), .ofly_burst_len(ofly_b),
    .cmd_valid(cmd_valid_b), .cmd_rdy(cmd_rdy_b), .datain_rdy(datain_rdy_b),
    .write_data(write_data_b), .data_mask(data_mask_b), .read_data(read_data_b),
    .read_data_valid(read_data_valid_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .dbg_state(dbg_state_b)
  );

  // ---------------- reference pattern ----------------
  function automatic logic [63:0] exp_beat(input logic [26:0] base, input int k);
`ifdef DDR3_TM_LFSR_PATTERN_EN
    logic [63:0] s;
    s = 64'h1;
    for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    return s;
`else
    logic [26:0] a;
    logic [9:0]  kk;
    a  = base + 27'(4 * k);
    kk = 10'(k);
    return {a, ~a, kk};
`endif
  endfunction

  // ---------------- controller / ideal memory model for A ----------------
  logic [30:0] cmd_log_a[$];
  logic [63:0] wdata_log_a[$];
  logic [26:0] wr_addr_q_a[$];
  logic [26:0] rd_addr_q_a[$];
  int          rd_ready_q_a[$];
  logic [63:0] mem [logic [26:0]];
  int          cyc = 0;
  int          rd_seen_a = 0;
  int          corrupt_left = 0;
  bit          rdy_block = 1'b0;
  bit          ret_hold = 1'b0;
  logic [26:0] wa, ra;
  logic [63:0] rdata;

  initial forever begin
    @(negedge sclk);
    if (!rst_n) begin
      cmd_rdy_a = 1'b0; datain_rdy_a = 1'b0; read_data_valid_a = 1'b0; read_data_a = 64'h0;
      wr_addr_q_a.delete(); rd_addr_q_a.delete(); rd_ready_q_a.delete();
    end else begin
      cyc++;
      if (wr_addr_q_a.size() > 0 && $urandom_range(0, 2) != 0) begin
        datain_rdy_a = 1'b1;
        wa = wr_addr_q_a.pop_front();
        mem[wa] = write_data_a;
        wdata_log_a.push_back(write_data_a);
      end else begin
        datain_rdy_a = 1'b0;
      end
      cmd_rdy_a = rdy_block ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (cmd_valid_a && cmd_rdy_a) begin
        cmd_log_a.push_back({cmd_a, addr_a});
        for (int i = 0; i < 2 * BC_A; i++) begin
          if (cmd_a == WR) begin
            wr_addr_q_a.push_back(addr_a + 27'(4 * i));
          end else begin
            rd_addr_q_a.push_back(addr_a + 27'(4 * i));
            rd_ready_q_a.push_back(cyc + 1 + int'($urandom_range(0, 3)));
          end
        end
      end
      if (!ret_hold && rd_addr_q_a.size() > 0 && rd_ready_q_a[0] <= cyc && $urandom_range(0, 3) != 0) begin
        ra = rd_addr_q_a.pop_front();
        void'(rd_ready_q_a.pop_front());
        rdata = mem.exists(ra) ? mem[ra] : 64'h0;
        if (corrupt_left > 0) begin
          rdata[0] = ~rdata[0];
          corrupt_left--;
        end
        read_data_a = rdata;
        read_data_valid_a = 1'b1;
        rd_seen_a++;
      end else begin
        read_data_valid_a = 1'b0;
      end
    end
  end

  // ---------------- controller model for B (no read returns) ----------------
  logic [30:0] cmd_log_b[$];
  logic [63:0] wdata_log_b[$];
  int          wr_owed_b = 0;

  initial forever begin
    @(negedge sclk);
    if (!rst_n) begin
      cmd_rdy_b = 1'b0; datain_rdy_b = 1'b0; wr_owed_b = 0;
    end else begin
      if (wr_owed_b > 0) begin
        datain_rdy_b = 1'b1;
        wdata_log_b.push_back(write_data_b);
        wr_owed_b--;
      end else begin
        datain_rdy_b = 1'b0;
      end
      cmd_rdy_b = 1'b1;
      if (cmd_valid_b) begin
        cmd_log_b.push_back({cmd_b, addr_b});
        if (cmd_b == WR) wr_owed_b = 2 * BC_B;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start_a;
    @(negedge sclk); start_a = 1'b1;
    @(negedge sclk); start_a = 1'b0;
  endtask

  task automatic clear_logs_a;
    cmd_log_a.delete(); wdata_log_a.delete(); rd_seen_a = 0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sclk);
      if (done_a === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    @(negedge sclk);
    checks++;
    if ({cmd_valid_a, cmd_a, addr_a, cmd_burst_cnt_a, init_start_a} !== 38'h0) begin
      errors++; $display("FAIL reset_cmd: got %h expected 0", {cmd_valid_a, cmd_a, addr_a, cmd_burst_cnt_a, init_start_a});
    end
    checks++;
    if ({busy_a, done_a, pass_a, err_count_a} !== 19'h0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", {busy_a, done_a, pass_a, err_count_a});
    end
    checks++;
    if ({write_data_a, data_mask_a, ofly_a} !== 73'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {write_data_a, data_mask_a, ofly_a});
    end
  endtask

  task automatic test_init;
    bit ok, held, seen;
    @(negedge sclk); rst_n = 1'b1;
    repeat (2) @(negedge sclk);
    init_done_a = 1'b0;
    rdy_block = 1'b1;
    clear_logs_a();
    pulse_start_a();
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!(init_start_a === 1'b1 && cmd_valid_a === 1'b0)) held = 1'b0;
      @(negedge sclk);
    end
    checks++;
    if (!held) begin errors++; $display("FAIL init_hold: got init_start=%b cmd_valid=%b expected 1/0", init_start_a, cmd_valid_a); end
    init_done_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sclk);
      if (cmd_valid_a === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || cmd_a !== WR || addr_a !== BASE_A || init_start_a !== 1'b0) begin
      errors++; $display("FAIL init_first_cmd: got valid=%b cmd=%b addr=%h init_start=%b expected 1/%b/%h/0", cmd_valid_a, cmd_a, addr_a, init_start_a, WR, BASE_A);
    end
    rdy_block = 1'b0;
    wait_done_a(3000, ok);
    checks++;
    if (!ok || pass_a !== 1'b1) begin errors++; $display("FAIL init_pass: got done=%b pass=%b expected 1/1", done_a, pass_a); end
  endtask

  task automatic test_full_pass;
    bit ok;
    logic [30:0] exp_cmd, got_cmd;
    logic [63:0] exp_q[$];
    logic [63:0] got_d, exp_d;
    clear_logs_a();
    pulse_start_a();
    checks++;
    if (cmd_valid_a !== 1'b1 || init_start_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL skip_init: got valid=%b init_start=%b done=%b expected 1/0/0", cmd_valid_a, init_start_a, done_a);
    end
    wait_done_a(3000, ok);
    checks++;
    if (!ok || pass_a !== 1'b1 || err_count_a !== 16'd0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL full_status: got done=%b pass=%b err=%0d busy=%b expected 1/1/0/0", done_a, pass_a, err_count_a, busy_a);
    end
    checks++;
    if (cmd_log_a.size() != 2 * N_A) begin errors++; $display("FAIL full_cmd_count: got %0d expected %0d", cmd_log_a.size(), 2 * N_A); end
    for (int i = 0; i < 2 * N_A; i++) begin
      exp_cmd = {(i < N_A) ? WR : RD, BASE_A + 27'((i % N_A) * 8 * BC_A)};
      got_cmd = (i < cmd_log_a.size()) ? cmd_log_a[i] : 31'h0;
      checks++;
      if (got_cmd !== exp_cmd) begin errors++; $display("FAIL full_cmd[%0d]: got %h expected %h", i, got_cmd, exp_cmd); end
    end
    for (int k = 0; k < 2 * BC_A * N_A; k++) exp_q.push_back(exp_beat(BASE_A, k));
    checks++;
    if (wdata_log_a.size() != exp_q.size()) begin errors++; $display("FAIL full_wbeat_count: got %0d expected %0d", wdata_log_a.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      exp_d = exp_q.pop_front();
      got_d = (k < wdata_log_a.size()) ? wdata_log_a[k] : 64'h0;
      checks++;
      if (got_d !== exp_d) begin errors++; $display("FAIL full_wbeat[%0d]: got %h expected %h", k, got_d, exp_d); end
    end
    checks++;
    if (rd_seen_a != 2 * BC_A * N_A) begin errors++; $display("FAIL full_rbeat_count: got %0d expected %0d", rd_seen_a, 2 * BC_A * N_A); end
  endtask

  task automatic test_cmd_stall;
    bit ok, stable;
    logic [3:0]  held_cmd;
    logic [26:0] held_addr;
    rdy_block = 1'b1;
    clear_logs_a();
    pulse_start_a();
    held_cmd = cmd_a;
    held_addr = addr_a;
    checks++;
    if (cmd_valid_a !== 1'b1 || held_cmd !== WR || held_addr !== BASE_A) begin
      errors++; $display("FAIL stall_first: got valid=%b cmd=%b addr=%h expected 1/%b/%h", cmd_valid_a, held_cmd, held_addr, WR, BASE_A);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      if (!(cmd_valid_a === 1'b1 && cmd_a === held_cmd && addr_a === held_addr)) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL stall_stable: got cmd=%b addr=%h expected %b/%h", cmd_a, addr_a, held_cmd, held_addr); end
    checks++;
    if (cmd_log_a.size() != 0) begin errors++; $display("FAIL stall_no_accept: got %0d expected 0", cmd_log_a.size()); end
    rdy_block = 1'b0;
    wait_done_a(3000, ok);
    checks++;
    if (!ok || cmd_log_a.size() != 2 * N_A || cmd_log_a[0] !== {WR, BASE_A} || cmd_log_a[1] !== {WR, BASE_A + 27'(8 * BC_A)}) begin
      errors++; $display("FAIL stall_accept_once: got done=%b cmds=%0d expected 1/%0d", done_a, cmd_log_a.size(), 2 * N_A);
    end
    checks++;
    if (pass_a !== 1'b1) begin errors++; $display("FAIL stall_pass: got %b expected 1", pass_a); end
  endtask

  task automatic test_start_ignored;
    bit ok, seen;
    clear_logs_a();
    pulse_start_a();
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge sclk);
      if (cmd_log_a.size() >= 2) seen = 1'b1;
    end
    pulse_start_a();
    checks++;
    if (!seen || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++; $display("FAIL busy_start: got seen=%b busy=%b done=%b expected 1/1/0", seen, busy_a, done_a);
    end
    wait_done_a(3000, ok);
    checks++;
    if (!ok || cmd_log_a.size() != 2 * N_A || wdata_log_a.size() != 2 * BC_A * N_A || pass_a !== 1'b1) begin
      errors++; $display("FAIL busy_start_pass: got done=%b cmds=%0d beats=%0d pass=%b expected 1/%0d/%0d/1", done_a, cmd_log_a.size(), wdata_log_a.size(), pass_a, 2 * N_A, 2 * BC_A * N_A);
    end
  endtask

  task automatic test_corrupt;
    bit ok;
    clear_logs_a();
    corrupt_left = 3;
    pulse_start_a();
    wait_done_a(3000, ok);
    checks++;
    if (!ok || pass_a !== 1'b0 || err_count_a !== 16'd3) begin
      errors++; $display("FAIL corrupt: got done=%b pass=%b err=%0d expected 1/0/3", done_a, pass_a, err_count_a);
    end
    repeat (8) @(negedge sclk);
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b0 || busy_a !== 1'b0 || err_count_a !== 16'd3) begin
      errors++; $display("FAIL done_hold: got done=%b pass=%b busy=%b err=%0d expected 1/0/0/3", done_a, pass_a, busy_a, err_count_a);
    end
  endtask

  task automatic test_addr_wrap;
    bit seen;
    logic [30:0] exp_cmd, got_cmd;
    logic [63:0] got_d;
    cmd_log_b.delete(); wdata_log_b.delete();
    @(negedge sclk); start_b = 1'b1;
    @(negedge sclk); start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge sclk);
      if (cmd_log_b.size() >= 2 * N_B) seen = 1'b1;
    end
    repeat (3) @(negedge sclk);
    checks++;
    if (!seen || cmd_log_b.size() != 2 * N_B) begin errors++; $display("FAIL wrap_cmd_count: got %0d expected %0d", cmd_log_b.size(), 2 * N_B); end
    for (int i = 0; i < 2 * N_B; i++) begin
      exp_cmd = {(i < N_B) ? WR : RD, BASE_B + 27'((i % N_B) * 8 * BC_B)};
      got_cmd = (i < cmd_log_b.size()) ? cmd_log_b[i] : 31'h0;
      checks++;
      if (got_cmd !== exp_cmd) begin errors++; $display("FAIL wrap_cmd[%0d]: got %h expected %h", i, got_cmd, exp_cmd); end
    end
    for (int k = 0; k < 2 * BC_B * N_B; k++) begin
      got_d = (k < wdata_log_b.size()) ? wdata_log_b[k] : 64'h0;
      checks++;
      if (got_d !== exp_beat(BASE_B, k)) begin errors++; $display("FAIL wrap_wbeat[%0d]: got %h expected %h", k, got_d, exp_beat(BASE_B, k)); end
    end
  endtask

  task automatic test_reset_mid_pass;
    bit ok, seen, quiet;
    ret_hold = 1'b1;
    clear_logs_a();
    pulse_start_a();
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge sclk);
      if (cmd_log_a.size() >= 2 * N_A) seen = 1'b1;
    end
    repeat (3) @(negedge sclk);
    checks++;
    if (!seen || busy_a !== 1'b1 || done_a !== 1'b0 || cmd_valid_a !== 1'b0) begin
      errors++; $display("FAIL rdwait_reached: got seen=%b busy=%b done=%b valid=%b expected 1/1/0/0", seen, busy_a, done_a, cmd_valid_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid_a, cmd_a, addr_a, cmd_burst_cnt_a, init_start_a, busy_a, done_a, pass_a, err_count_a, write_data_a} !== 121'h0) begin
      errors++; $display("FAIL async_reset_a: got %h expected 0", {cmd_valid_a, cmd_a, addr_a, cmd_burst_cnt_a, init_start_a, busy_a, done_a, pass_a, err_count_a, write_data_a});
    end
    checks++;
    if ({cmd_valid_b, cmd_b, addr_b, busy_b, write_data_b} !== 97'h0) begin
      errors++; $display("FAIL async_reset_b: got %h expected 0", {cmd_valid_b, cmd_b, addr_b, busy_b, write_data_b});
    end
    repeat (3) @(negedge sclk);
    ret_hold = 1'b0;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      if (cmd_valid_a !== 1'b0 || busy_a !== 1'b0 || write_data_a !== 64'h0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || cmd_log_a.size() != 2 * N_A) begin
      errors++; $display("FAIL reset_abandon: got valid=%b busy=%b cmds=%0d expected 0/0/%0d", cmd_valid_a, busy_a, cmd_log_a.size(), 2 * N_A);
    end
    clear_logs_a();
    pulse_start_a();
    wait_done_a(3000, ok);
    checks++;
    if (!ok || pass_a !== 1'b1 || err_count_a !== 16'd0 || cmd_log_a.size() != 2 * N_A || rd_seen_a != 2 * BC_A * N_A) begin
      errors++; $display("FAIL post_reset_pass: got done=%b pass=%b err=%0d cmds=%0d rbeats=%0d expected 1/1/0/%0d/%0d", done_a, pass_a, err_count_a, cmd_log_a.size(), rd_seen_a, 2 * N_A, 2 * BC_A * N_A);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_init();
    test_full_pass();
    test_cmd_stall();
    test_start_ignored();
    test_corrupt();
    test_addr_wrap();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_traffic_master.md
DDR3_TRAFFIC_MASTER -- requirements
Module: ddr3_traffic_master

Interface
REQ-001 Parameter ADDR_BASE, default 27'h0, first 27-bit memory address tested.
REQ-002 Parameter NUM_CMDS, default 1024, number of write commands (and read commands) per pass, range 1..65535.
REQ-003 Parameter BURST_CNT, default 5'd4, cmd_burst_cnt value issued, 1..31; 0 means 32.
REQ-004 sclk  in  1  sole clock, the controller's sclk_out; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset, deassertion synchronous to sclk.
REQ-006 start  in  1  one-cycle pulse, begins a test pass when idle.
REQ-007 init_start  out  1  request to controller to run memory initialisation.
REQ-008 init_done  in  1  controller initialisation complete.
REQ-009 cmd  out  4  command code: 4'b0010 WRITE, 4'b0001 READ.
REQ-010 addr  out  27  command start address.
REQ-011 cmd_burst_cnt  out  5  bursts per command.
REQ-012 ofly_burst_len  out  1  tied 0 (fixed BL8).
REQ-013 cmd_valid / cmd_rdy  out / in  1 / 1  command handshake.
REQ-014 datain_rdy  in  1  controller consumes one write beat this cycle.
REQ-015 write_data / data_mask  out / out  64 / 8  write beat; data_mask tied 8'h00.
REQ-016 read_data / read_data_valid  in / in  64 / 1  returned read beat.
REQ-017 busy, done, pass  out  1 each  status; err_count out 16 saturating mismatch count.

Function
REQ-018 FSM states SHALL be IDLE, INIT, WR_CMD, WR_DATA, RD_CMD, RD_WAIT, FINISH.
REQ-019 IDLE->INIT on start; INIT SHALL hold init_start=1 until init_done=1, then go WR_CMD; if init_done already 1, SHALL skip INIT directly to WR_CMD.
REQ-020 A command SHALL transfer only in a cycle with cmd_valid=1 and cmd_rdy=1; cmd, addr, cmd_burst_cnt SHALL stay stable while cmd_valid=1 and cmd_rdy=0.
REQ-021 Each command carries BURST_CNT bursts; each burst = 2 beats of 64 bits; addr SHALL advance by 8*BURST_CNT per command (27-bit wrap-around at 2^27).
REQ-022 WR_CMD issues one WRITE, then WR_DATA supplies exactly 2*BURST_CNT beats, one per datain_rdy=1 cycle; next beat SHALL be on write_data the cycle after each consuming cycle.
REQ-023 After NUM_CMDS writes, addr SHALL reload ADDR_BASE and RD_CMD SHALL issue NUM_CMDS READs back-to-back without waiting for data.
REQ-024 Outstanding read beats SHALL be counted (16-bit+); RD_WAIT->FINISH when all 2*BURST_CNT*NUM_CMDS beats received.
REQ-025 Each read_data_valid beat SHALL be compared to the regenerated expected pattern; mismatch increments err_count, saturating at 16'hFFFF.
REQ-026 read_data_valid arriving during RD_CMD SHALL be checked normally (commands and returns overlap).
REQ-027 Beat k pattern (default): {addr_of_beat[26:0], ~addr_of_beat[26:0], k[9:0]} truncated to 64 bits, addr_of_beat = command addr + 4*beat index within command.
REQ-028 FINISH SHALL set done=1, pass=(err_count==0), busy=0, then go IDLE; done/pass hold until next start.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 busy=1 in every state except IDLE.

Reset
REQ-031 On rst_n=0 all outputs SHALL be 0 (cmd=4'b0000, addr=0, cmd_burst_cnt=0, err_count=0), FSM=IDLE, counters cleared, asynchronously.
REQ-032 Reset mid-pass SHALL abandon the pass; no command or beat issued until next start.

Configuration
REQ-033 Macro DDR3_TM_LFSR_PATTERN_EN defined: write/expected data SHALL be a 64-bit Galois LFSR (taps 64,63,61,60), seed 64'h1, stepped once per beat, reseeded at start of write and read phases.
REQ-034 Macro undefined: address-based pattern of REQ-027; no LFSR logic present.

Verification
REQ-035 Reset, init_done=0, start -> init_start=1 until init_done driven 1, then first cmd_valid with cmd=4'b0010, addr=ADDR_BASE.
REQ-036 NUM_CMDS=2, BURST_CNT=4, cmd_rdy always 1, ideal memory model -> 2 WRITEs (addr 0, 32), 16 write beats, 2 READs, 16 read beats, done=1, pass=1, err_count=0.
REQ-037 cmd_rdy held 0 for 5 cycles during WRITE -> cmd/addr stable all 5 cycles, exactly one command accepted.
REQ-038 Model corrupts bit 0 of 3 read beats -> done=1, pass=0, err_count=3.
REQ-039 ADDR_BASE=27'h7FFFFF8, BURST_CNT=1, NUM_CMDS=2 -> second addr=27'h0000000.
REQ-040 rst_n pulsed low during RD_WAIT -> all outputs 0 immediately; subsequent start runs a full passing pass.
